// File: rtl/dispatcher_cpuid_ng.sv
// CPU-ID allocator for the dispatcher stage.
// Answers each level-held request from Input with a CPU ID chosen by one of four modes
// (strict RR, port bind, skip-invalid RR, bind with fallback), gated by a live per-CPU
// ready mask, and keeps grant / no-CPU statistics.
module dispatcher_cpuid_ng #(
   parameter int unsigned CPU_NUM = 32,
   parameter int unsigned CPUID_W = $clog2(CPU_NUM),
   parameter int unsigned CNT_W   = 32
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [1:0]         in_mode,
   input  logic [CPUID_W:0]   in_channel_num,
   input  logic [CPU_NUM-1:0] cpuid_valid,
   input  logic [CPUID_W-1:0] in_input_key,
   input  logic               in_input_ctl,
   output logic               out_input_ack,
   output logic               out_input_valid,
   output logic [CPUID_W-1:0] out_input_cpuid,
   output logic [CNT_W-1:0]   out_grant_cnt,
   output logic [CNT_W-1:0]   out_novalid_cnt
);

   // Channel counts need one extra bit so that CPU_NUM itself is representable.
   localparam int unsigned NW = CPUID_W + 1;
   localparam logic [NW-1:0] CpuNumN = NW'(CPU_NUM);

   localparam logic [1:0] ModeStrictRr = 2'd0;
   localparam logic [1:0] ModeBind     = 2'd1;
   localparam logic [1:0] ModeSkipRr   = 2'd2;
   localparam logic [1:0] ModeBindFb   = 2'd3;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StCheck = 2'd1,
      StWait  = 2'd2
   } state_e;

   state_e             state_q, state_d;
   logic [1:0]         mode_q, mode_d;
   logic [NW-1:0]      n_q, n_d;
   logic [CPUID_W-1:0] cand_q, cand_d;
   logic [NW-1:0]      tries_q, tries_d;
   logic [CPUID_W-1:0] rr_ptr_q, rr_ptr_d;
   logic               ack_q, ack_d;
   logic               valid_q, valid_d;
   logic [CPUID_W-1:0] cpuid_q, cpuid_d;
   logic [CNT_W-1:0]   grant_cnt_q, grant_cnt_d;
   logic [CNT_W-1:0]   novalid_cnt_q, novalid_cnt_d;

   logic [NW-1:0]      n_eff;
   logic               hit;
   logic               rr_mode;
   logic               last_try;
   logic [CPUID_W-1:0] cand_next;

   // Round-robin successor within the active channel window.
   function automatic logic [CPUID_W-1:0] next_cand(input logic [CPUID_W-1:0] x,
                                                    input logic [NW-1:0]      n);
      logic [NW-1:0] inc;
      inc = {1'b0, x} + NW'(1);
      return (inc >= n) ? '0 : inc[CPUID_W-1:0];
   endfunction

   // Effective channel count: 0 or anything above CPU_NUM selects all CPUs.
   always_comb begin
      n_eff = in_channel_num;
      if (in_channel_num == '0 || in_channel_num > CpuNumN) begin
         n_eff = CpuNumN;
      end
   end

   // Live ready lookup of the current candidate; IDs past CPU_NUM never hit.
   always_comb begin
      hit = 1'b0;
      for (int unsigned i = 0; i < CPU_NUM; i++) begin
         if (cand_q == CPUID_W'(i)) begin
            hit = cpuid_valid[i];
         end
      end
   end

   // Search helpers shared by the next-state logic.
   always_comb begin
      rr_mode   = (mode_q == ModeStrictRr) || (mode_q == ModeSkipRr);
      last_try  = (tries_q == n_q - NW'(1));
      cand_next = next_cand(cand_q, n_q);
   end

   // Next-state and output-register logic of the allocation FSM.
   always_comb begin
      state_d       = state_q;
      mode_d        = mode_q;
      n_d           = n_q;
      cand_d        = cand_q;
      tries_d       = tries_q;
      rr_ptr_d      = rr_ptr_q;
      ack_d         = ack_q;
      valid_d       = valid_q;
      cpuid_d       = cpuid_q;
      grant_cnt_d   = grant_cnt_q;
      novalid_cnt_d = novalid_cnt_q;

      case (state_q)
         StIdle: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            if (in_input_ctl) begin
               mode_d  = in_mode;
               n_d     = n_eff;
               tries_d = '0;
               state_d = StCheck;
               if (in_mode == ModeStrictRr || in_mode == ModeSkipRr) begin
                  // A pointer left over from a wider window restarts at CPU 0.
                  cand_d = ({1'b0, rr_ptr_q} >= n_eff) ? '0 : rr_ptr_q;
               end else begin
                  cand_d = in_input_key;
               end
            end
         end

         StCheck: begin
            if (!in_input_ctl) begin
               // Request withdrawn: drop the search without side effects.
               state_d = StIdle;
            end else if (hit) begin
               cpuid_d     = cand_q;
               ack_d       = 1'b1;
               valid_d     = 1'b1;
               grant_cnt_d = grant_cnt_q + CNT_W'(1);
               state_d     = StWait;
               if (rr_mode) begin
                  rr_ptr_d = cand_next;
               end
            end else begin
               case (mode_q)
                  ModeStrictRr: begin
                     // Input keeps the request up, so the retry lands on the next CPU.
                     rr_ptr_d = cand_next;
                     state_d  = StIdle;
                  end
                  ModeBind: begin
                     cpuid_d       = cand_q;
                     ack_d         = 1'b1;
                     valid_d       = 1'b0;
                     novalid_cnt_d = novalid_cnt_q + CNT_W'(1);
                     state_d       = StWait;
                  end
                  ModeSkipRr, ModeBindFb: begin
                     if (last_try) begin
                        cpuid_d       = cand_q;
                        ack_d         = 1'b1;
                        valid_d       = 1'b0;
                        novalid_cnt_d = novalid_cnt_q + CNT_W'(1);
                        state_d       = StWait;
                        if (rr_mode) begin
                           rr_ptr_d = cand_next;
                        end
                     end else begin
                        cand_d  = cand_next;
                        tries_d = tries_q + NW'(1);
                     end
                  end
                  default: state_d = StIdle;
               endcase
            end
         end

         StWait: begin
            if (!in_input_ctl) begin
               ack_d   = 1'b0;
               valid_d = 1'b0;
               state_d = StIdle;
            end
         end

         default: begin
            ack_d   = 1'b0;
            valid_d = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State and output registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         mode_q        <= ModeStrictRr;
         n_q           <= CpuNumN;
         cand_q        <= '0;
         tries_q       <= '0;
         rr_ptr_q      <= '0;
         ack_q         <= 1'b0;
         valid_q       <= 1'b0;
         cpuid_q       <= '0;
         grant_cnt_q   <= '0;
         novalid_cnt_q <= '0;
      end else begin
         state_q       <= state_d;
         mode_q        <= mode_d;
         n_q           <= n_d;
         cand_q        <= cand_d;
         tries_q       <= tries_d;
         rr_ptr_q      <= rr_ptr_d;
         ack_q         <= ack_d;
         valid_q       <= valid_d;
         cpuid_q       <= cpuid_d;
         grant_cnt_q   <= grant_cnt_d;
         novalid_cnt_q <= novalid_cnt_d;
      end
   end

   assign out_input_ack   = ack_q;
   assign out_input_valid = valid_q;
   assign out_input_cpuid = cpuid_q;
   assign out_grant_cnt   = grant_cnt_q;
   assign out_novalid_cnt = novalid_cnt_q;

endmodule
